// File: rtl/serial_byte_receiver_if.sv
// Consumer-side handshake of the serial byte receiver: completed word, valid/ack, status flags.
// parity_err exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_byte_receiver_if #(
    parameter int width = 8
);
    logic [width-1:0] parallelout;
    logic             data_valid;
    logic             overrun;
    logic             busy;
    logic             rd_ack;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output parallelout, data_valid, overrun, busy,
`ifdef SERIAL_RX_PARITY_EN
        output parity_err,
`endif
        input  rd_ack
    );

    modport slave (
        input  parallelout, data_valid, overrun, busy,
`ifdef SERIAL_RX_PARITY_EN
        input  parity_err,
`endif
        output rd_ack
    );
endinterface

// File: rtl/serial_byte_receiver.sv
// Serial link receiver: synchronizes raw sclk/cs_n/sdata, shifts words in MSB first, held valid/ack.
// Optional trailing even-parity bit and parity_err output enabled by SERIAL_RX_PARITY_EN.
module serial_byte_receiver #(
    parameter int width = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk_in,
    input  logic cs_n_in,
    input  logic sdata_in,
    serial_byte_receiver_if.master bus
);
    localparam int CW = $clog2(width);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SERIAL_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q;
    logic sd_s1_q, sd_s2_q;
    logic rise;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [width-1:0]  shift_q, shift_d;
    logic [width-1:0]  po_q, po_d;
    logic              dv_q, dv_d;
    logic              ov_q, ov_d;
    logic [width-1:0]  shifted;
    logic              word_done;
`ifdef SERIAL_RX_PARITY_EN
    logic              pe_q, pe_d;
    logic              pe_new;
`endif

    // sdata is sampled at the same stage that flags the sclk rise, so both see the same raw instant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            sd_s1_q   <= 1'b0;
            sd_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q <= sclk_in;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= cs_n_in;
            cs_s2_q   <= cs_s1_q;
            sd_s1_q   <= sdata_in;
            sd_s2_q   <= sd_s1_q;
        end
    end

    assign rise    = sclk_s2_q & ~sclk_s3_q;
    assign shifted = {shift_q[width-2:0], sd_s2_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            po_q    <= '0;
            dv_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            po_q    <= po_d;
            dv_q    <= dv_d;
            ov_q    <= ov_d;
`ifdef SERIAL_RX_PARITY_EN
            pe_q    <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        po_d      = po_q;
        dv_d      = dv_q;
        ov_d      = ov_q;
        word_done = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        pe_d      = pe_q;
        pe_new    = 1'b0;
`endif

        if (bus.rd_ack && dv_q) begin
            dv_d = 1'b0;
            ov_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            pe_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!cs_s2_q) state_d = SHIFT;
            end
            SHIFT: begin
                if (rise) begin
                    shift_d = shifted;
                    if (cnt_q == CW'(width - 1)) begin
                        cnt_d = '0;
                        po_d  = shifted;
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                // Frame end: a word finishing on this edge is already handled above
                if (cs_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (rise) begin
                    word_done = 1'b1;
                    pe_new    = ^{po_q, sd_s2_q};
                    state_d   = SHIFT;
                end
                if (cs_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A simultaneous ack consumes the old word, so no overrun and the flag is left as it was
        if (word_done) begin
            dv_d = 1'b1;
            ov_d = (dv_q && !bus.rd_ack) ? 1'b1 : ov_q;
`ifdef SERIAL_RX_PARITY_EN
            pe_d = pe_new;
`endif
        end
    end

    assign bus.parallelout = po_q;
    assign bus.data_valid  = dv_q;
    assign bus.overrun     = ov_q;
    assign bus.busy        = ~cs_s2_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err  = pe_q;
`endif
endmodule
